// File: rtl/morph_pass_ctrl_if.sv
// Camera-side sync/pixel inputs, sequencer controls and status outputs of the
// morphology frame sequencer, bundled for connection to morph_pass_ctrl.
interface morph_pass_ctrl_if;
    logic        cam_href;
    logic        cam_vsync;
    logic        din_val;
    logic [1:0]  mode_cfg;
    logic        cont_cfg;
    logic        start;
    logic        stop;
    logic        eps_crs;
    logic        pass_idx;
    logic        busy;
    logic        border_mask;
    logic [11:0] line_cnt;
    logic [10:0] pix_cnt;
    logic        frame_done;
    logic        err_pix;

    modport master (
        output cam_href, cam_vsync, din_val, mode_cfg, cont_cfg, start, stop,
        input  eps_crs, pass_idx, busy, border_mask, line_cnt, pix_cnt,
               frame_done, err_pix
    );

    modport slave (
        input  cam_href, cam_vsync, din_val, mode_cfg, cont_cfg, start, stop,
        output eps_crs, pass_idx, busy, border_mask, line_cnt, pix_cnt,
               frame_done, err_pix
    );
endinterface

// File: rtl/morph_pass_ctrl.sv
// Frame-level sequencer for the binary morphology stage: sync edge detection,
// line/pixel counting, border mask and per-frame erode/dilate pass selection.
module morph_pass_ctrl #(
    parameter int H_ACT  = 1280,
    parameter int BORDER = 2
) (
    input  logic              module_clk,
    input  logic              module_rst_n,
    morph_pass_ctrl_if.slave  bus
);
    localparam logic [10:0] PIX_MAX  = 11'(H_ACT);
    localparam logic [11:0] LINE_MAX = 12'hFFF;
    localparam logic [11:0] BORDER_L = 12'(BORDER);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_PASS1, S_PASS2, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        href_s1_q, href_s2_q, vsync_s1_q, vsync_s2_q;
    logic        href_rise_q, href_rise_d;
    logic        vsync_rise_q, vsync_rise_d;
    logic [11:0] line_cnt_q, line_cnt_d;
    logic [10:0] pix_cnt_q, pix_cnt_d;
    logic [1:0]  mode_q, mode_d;
    logic        cont_q, cont_d;
    logic        stop_pend_q, stop_pend_d;
    logic        eps_crs_q, eps_crs_d;
    logic        pass_idx_q, pass_idx_d;
    logic        busy_q, busy_d;
    logic        border_mask_q, border_mask_d;
    logic        frame_done_q, frame_done_d;
    logic        err_pix_q, err_pix_d;

    // NOTE: every _d gets a default from its _q first, so no path leaves a
    // combinational signal unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        cont_d        = cont_q;
        stop_pend_d   = stop_pend_q;
        line_cnt_d    = line_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        err_pix_d     = err_pix_q;
        eps_crs_d     = eps_crs_q;
        href_rise_d   = href_s1_q & ~href_s2_q;
        vsync_rise_d  = vsync_s1_q & ~vsync_s2_q;

        if (vsync_rise_q) begin
            line_cnt_d = '0;
        end else if (href_rise_q && line_cnt_q != LINE_MAX) begin
            line_cnt_d = line_cnt_q + 12'd1;
        end

        if (href_rise_q) begin
            pix_cnt_d = '0;
        end else if (bus.din_val && href_s1_q && pix_cnt_q != PIX_MAX) begin
            pix_cnt_d = pix_cnt_q + 11'd1;
        end

        if (bus.din_val && pix_cnt_q == PIX_MAX) begin
            err_pix_d = 1'b1;
        end

        if (state_q == S_IDLE) begin
            stop_pend_d = 1'b0;
        end else if (bus.stop) begin
            stop_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mode_d    = bus.mode_cfg;
                    cont_d    = bus.cont_cfg;
                    err_pix_d = 1'b0;
                    state_d   = S_ARM;
                end
            end
            S_ARM: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (vsync_rise_q) begin
                    state_d = S_PASS1;
                end
            end
            S_PASS1: begin
                if (vsync_rise_q) begin
                    state_d = mode_q[1] ? S_PASS2 : S_DONE;
                end
            end
            S_PASS2: begin
                if (vsync_rise_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // The next frame has already begun, so a continuous run skips ARM.
                state_d = (cont_q && !stop_pend_q && !bus.stop) ? S_PASS1 : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // PASS1 erodes for 00/10, PASS2 (10/11 only) runs the complementary op.
        if (state_d == S_PASS1) begin
            eps_crs_d = ~mode_d[0];
        end else if (state_d == S_PASS2) begin
            eps_crs_d = mode_d[0];
        end

        pass_idx_d    = (state_d == S_PASS2);
        busy_d        = (state_d != S_IDLE);
        frame_done_d  = (state_d == S_DONE);
        border_mask_d = (line_cnt_d != 12'd0) && (line_cnt_d <= BORDER_L);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge module_clk) begin
        if (!module_rst_n) begin
            state_q       <= S_IDLE;
            href_s1_q     <= 1'b0;
            href_s2_q     <= 1'b0;
            vsync_s1_q    <= 1'b0;
            vsync_s2_q    <= 1'b0;
            href_rise_q   <= 1'b0;
            vsync_rise_q  <= 1'b0;
            line_cnt_q    <= '0;
            pix_cnt_q     <= '0;
            mode_q        <= 2'b00;
            cont_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            eps_crs_q     <= 1'b1;
            pass_idx_q    <= 1'b0;
            busy_q        <= 1'b0;
            border_mask_q <= 1'b0;
            frame_done_q  <= 1'b0;
            err_pix_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            href_s1_q     <= bus.cam_href;
            href_s2_q     <= href_s1_q;
            vsync_s1_q    <= bus.cam_vsync;
            vsync_s2_q    <= vsync_s1_q;
            href_rise_q   <= href_rise_d;
            vsync_rise_q  <= vsync_rise_d;
            line_cnt_q    <= line_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            mode_q        <= mode_d;
            cont_q        <= cont_d;
            stop_pend_q   <= stop_pend_d;
            eps_crs_q     <= eps_crs_d;
            pass_idx_q    <= pass_idx_d;
            busy_q        <= busy_d;
            border_mask_q <= border_mask_d;
            frame_done_q  <= frame_done_d;
            err_pix_q     <= err_pix_d;
        end
    end

    assign bus.eps_crs     = eps_crs_q;
    assign bus.pass_idx    = pass_idx_q;
    assign bus.busy        = busy_q;
    assign bus.border_mask = border_mask_q;
    assign bus.line_cnt    = line_cnt_q;
    assign bus.pix_cnt     = pix_cnt_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.err_pix     = err_pix_q;
endmodule
